// File: rtl/m_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m_seq_pkg
//  Brief    : Shared PN polynomial (x^6+x^5+1), checker state encoding and
//             next-word function used by m_seq and m_seq_check.
//  Revision : 1.0 - initial release
// ============================================================================
package m_seq_pkg;

  // PN word width and feedback tap positions of x^6 + x^5 + 1
  localparam int c_pn_width = 6;
  localparam int c_tap_hi   = 5;
  localparam int c_tap_lo   = 4;

  // Checker FSM states; encoding is visible on the debug state port
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next word of the sequence: shift left, feed back tap_hi ^ tap_lo into bit 0
  function automatic logic [c_pn_width-1:0] pn_next(input logic [c_pn_width-1:0] w);
    return {w[c_pn_width-2:0], w[c_tap_hi] ^ w[c_tap_lo]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_seq_check.sv
`default_nettype none
// ============================================================================
//  Module   : m_seq_check
//  Brief    : PN sequence checker. Seeds its predictor from the received
//             stream, declares lock after LOCK_CNT consecutive matches,
//             flywheels through isolated errors while locked and resyncs after
//             MISS_MAX consecutive mismatches. Counts errors seen in lock.
//  Options  : M_SEQ_CHECK_SATURATE_EN - err_count saturates instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module m_seq_check
  import m_seq_pkg::*;
#(
  parameter int N        = c_pn_width,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             new_Game_n,
  input  logic             pn_valid,
  input  logic [N-1:0]     pn_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [3:0]       c_miss_max = 4'(MISS_MAX);
  localparam logic [CNT_W-1:0] c_err_one  = CNT_W'(1);

  state_t         r_state;
  logic [N-1:0]   r_pred;
  logic [3:0]     r_match_run;
  logic [3:0]     r_miss_run;

  logic [N-1:0]     w_next_in;
  logic [N-1:0]     w_next_fly;
  logic             w_hit;
  logic [3:0]       w_match_inc;
  logic [3:0]       w_miss_inc;
  logic [CNT_W-1:0] w_err_next;

  // Reseed from the received word; flywheel advances the predictor on its own
  assign w_next_in   = pn_next(pn_in);
  assign w_next_fly  = pn_next(r_pred);
  assign w_hit       = (pn_in == r_pred);
  assign w_match_inc = r_match_run + 4'd1;
  assign w_miss_inc  = r_miss_run + 4'd1;

`ifdef M_SEQ_CHECK_SATURATE_EN
  assign w_err_next = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + c_err_one;
`else
  assign w_err_next = err_count + c_err_one;
`endif

  assign state = r_state;

  // Seed / search / lock FSM with its run counters, error strobe and counter
  always_ff @(posedge clock or negedge new_Game_n) begin
    if (!new_Game_n) begin
      r_state     <= ST_IDLE;
      r_pred      <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (pn_valid) begin
        case (r_state)
          ST_IDLE: begin
            // an all-zero word is the LFSR lock-up state and cannot seed
            if (pn_in != '0) begin
              r_pred      <= w_next_in;
              r_match_run <= '0;
              r_state     <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            if (w_hit) begin
              r_match_run <= w_match_inc;
              r_pred      <= w_next_in;
              if (w_match_inc == c_lock_cnt) begin
                r_state    <= ST_LOCKED;
                locked     <= 1'b1;
                r_miss_run <= '0;
              end
            end else if (pn_in == '0) begin
              r_match_run <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_match_run <= '0;
              r_pred      <= w_next_in;
            end
          end
          ST_LOCKED: begin
            if (w_hit) begin
              r_pred     <= w_next_in;
              r_miss_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              err_count <= w_err_next;
              if (w_miss_inc == c_miss_max) begin
                // too many misses in a row: drop lock and reseed from this word
                r_state     <= ST_SEARCH;
                locked      <= 1'b0;
                r_miss_run  <= '0;
                r_match_run <= '0;
                r_pred      <= w_next_in;
              end else begin
                r_miss_run <= w_miss_inc;
                r_pred     <= w_next_fly;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_seq_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_seq_check
//  Brief    : Self-checking bench for m_seq_check. A behavioural model tracks
//             the expected checker mode, predictor and error total; a compare
//             process checks every cycle. Directed scenarios pin the model,
//             then a randomized stream with gaps, errors, zeros and resets runs.
//             A second instance with CNT_W=2 exercises wrap / saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m_seq_check;

  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 3;

  logic        clock;
  logic        new_Game_n;
  logic        pn_valid;
  logic [5:0]  pn_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked2;
  logic        err_pulse2;
  logic [1:0]  err_count2;
  logic [1:0]  state2;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // behavioural model: mode 0=unseeded, 1=searching, 2=locked
  int         m_mode;
  logic [5:0] m_pred;
  int         m_match;
  int         m_miss;
  int         m_errs;
  bit         m_pulse;

  m_seq_check #(.N(6), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .CNT_W(16)) dut (
    .clock(clock), .new_Game_n(new_Game_n), .pn_valid(pn_valid), .pn_in(pn_in),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  m_seq_check #(.N(6), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .CNT_W(2)) dut_w2 (
    .clock(clock), .new_Game_n(new_Game_n), .pn_valid(pn_valid), .pn_in(pn_in),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .state(state2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // x^6+x^5+1 successor, computed arithmetically
  function automatic logic [5:0] nx(input logic [5:0] w);
    int v;
    v = int'(w);
    return 6'(((v * 2) % 64) + (((v / 32) + (v / 16)) % 2));
  endfunction

  // a guaranteed non-matching, non-zero word
  function automatic logic [5:0] bad(input logic [5:0] p);
    return (p == 6'h21) ? 6'h3F : (p ^ 6'h21);
  endfunction

  function automatic longint exp_cnt(input int total, input int width);
    int lim;
    lim = 1 << width;
`ifdef M_SEQ_CHECK_SATURATE_EN
    return (total >= lim) ? longint'(lim - 1) : longint'(total);
`else
    return longint'(total % lim);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pred = '0; m_match = 0; m_miss = 0; m_errs = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input logic [5:0] w);
    m_pulse = 0;
    if (!v) return;
    if (m_mode == 0) begin
      if (w != 0) begin m_pred = nx(w); m_match = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (w == m_pred) begin
        m_match++;
        m_pred = nx(w);
        if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
      end else if (w == 0) begin
        m_match = 0; m_mode = 0;
      end else begin
        m_match = 0; m_pred = nx(w);
      end
    end else begin
      if (w == m_pred) begin
        m_pred = nx(w); m_miss = 0;
      end else begin
        m_pulse = 1; m_errs++; m_miss++;
        if (m_miss == MISS_MAX) begin
          m_mode = 1; m_miss = 0; m_match = 0; m_pred = nx(w);
        end else begin
          m_pred = nx(m_pred);
        end
      end
    end
  endtask

  // one clocked word; inputs change just after the rising edge
  task automatic step(input bit v, input logic [5:0] w);
    pn_valid = v;
    pn_in    = w;
    @(posedge clock);
    model_step(v, w);
    #1;
  endtask

  task automatic do_reset();
    new_Game_n = 1'b0;
    pn_valid   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 new_Game_n = 1'b1;
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("state",      longint'(state),      longint'(m_mode));
      check("locked",     longint'(locked),     longint'(m_mode == 2));
      check("err_pulse",  longint'(err_pulse),  longint'(m_pulse));
      check("err_count",  longint'(err_count),  exp_cnt(m_errs, 16));
      check("state_w2",   longint'(state2),     longint'(m_mode));
      check("err_count2", longint'(err_count2), exp_cnt(m_errs, 2));
    end
  end

  initial begin
    logic [5:0] t;
    int err_pct;
    new_Game_n = 1'b0;
    pn_valid   = 1'b0;
    pn_in      = '0;
    model_reset();
    chk_en = 1;

    // reset, then idle with random data and no valid
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 6'($urandom));
    check("idle_state", longint'(state), 0);
    check("idle_locked", longint'(locked), 0);
    check("idle_err", longint'(err_count), 0);

    // acquire lock on 000001..010000
    step(1'b1, 6'h01);
    check("seed_state", longint'(state), 1);
    step(1'b1, 6'h02); step(1'b1, 6'h04); step(1'b1, 6'h08);
    check("pre_lock", longint'(locked), 0);
    step(1'b1, 6'h10);
    check("lock_locked", longint'(locked), 1);
    check("lock_state", longint'(state), 2);
    check("lock_err", longint'(err_count), 0);
    check("model_pred_21", longint'(m_pred), longint'(6'h21));

    // single error, flywheel carries through
    step(1'b1, 6'h3F);
    check("err1_pulse", longint'(err_pulse), 1);
    check("err1_count", longint'(err_count), 1);
    check("err1_locked", longint'(locked), 1);
    step(1'b1, 6'h03);
    check("fly_pulse", longint'(err_pulse), 0);
    check("fly_count", longint'(err_count), 1);
    check("fly_locked", longint'(locked), 1);
    check("model_pred_06", longint'(m_pred), longint'(6'h06));

    // three consecutive errors force resync, then relock on the true stream
    t = 6'h03;
    for (int i = 0; i < 3; i++) begin
      t = nx(t);
      step(1'b1, bad(m_pred));
      if (i == 1) check("miss2_locked", longint'(locked), 1);
    end
    check("resync_err", longint'(err_count), 4);
    check("resync_locked", longint'(locked), 0);
    check("resync_state", longint'(state), 1);
    for (int i = 0; i < 5; i++) begin
      t = nx(t);
      step(1'b1, t);
      if (i == 2) check("relock_early", longint'(locked), 0);
    end
    check("relock_locked", longint'(locked), 1);

    // zeros never seed; gaps hold state during acquisition
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 6'h00);
    check("zero_idle", longint'(state), 0);
    t = 6'h15;
    step(1'b1, t);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'($urandom));
      t = nx(t);
      step(1'b1, t);
    end
    check("gap_locked", longint'(locked), 1);

    // asynchronous reset in the middle of a cycle while locked
    step(1'b1, bad(m_pred));
    check("pre_rst_err", longint'(err_count), 1);
    new_Game_n = 1'b0;
    model_reset();
    #1;
    check("rst_locked", longint'(locked), 0);
    check("rst_err", longint'(err_count), 0);
    check("rst_state", longint'(state), 0);
    pn_valid = 1'b0;
    @(posedge clock);
    #1 new_Game_n = 1'b1;
    step(1'b1, 6'h2A);
    check("post_rst_seed", longint'(state), 1);

    // five isolated errors in lock: narrow counter wraps or saturates
    do_reset();
    t = 6'h01;
    step(1'b1, t);
    for (int i = 0; i < 4; i++) begin t = nx(t); step(1'b1, t); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, bad(m_pred));
      if (k < 4) step(1'b1, m_pred);
    end
    check("five_err16", longint'(err_count), 5);
    check("five_locked", longint'(locked), 1);
`ifdef M_SEQ_CHECK_SATURATE_EN
    check("five_err2", longint'(err_count2), 3);
`else
    check("five_err2", longint'(err_count2), 1);
`endif

    // randomized stream: gaps, error bursts, zeros, occasional resets
    do_reset();
    t = 6'h01;
    for (int c = 0; c < 4000; c++) begin
      int r;
      err_pct = ((c / 400) % 2 == 1) ? 40 : 4;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        do_reset();
      end else if (r < 250) begin
        step(1'b0, 6'($urandom));
      end else begin
        t = nx(t);
        r = int'($urandom_range(0, 99));
        if (r < 2) step(1'b1, 6'h00);
        else if (r < err_pct) step(1'b1, t ^ 6'($urandom_range(1, 63)));
        else step(1'b1, t);
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
